// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: control block for the staged FFT pipeline.
// Accepts one transform request at a time, fires one start pulse per stage
// in order, waits for each stage's finish strobe, and guards every stage with
// a watchdog. Also drives the twiddle-mux stage index and a completed-frame counter.
module fft_stage_sequencer #(
    parameter int NUM_STAGES      = 5,
    parameter int TIMEOUT         = 15,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fft_start,
    output logic                       fft_ready,
    output logic                       fft_busy,
    output logic                       fft_done,
    output logic                       fft_error,
    input  logic                       abort,
    output logic [NUM_STAGES-1:0]      stage_start,
    input  logic [NUM_STAGES-1:0]      stage_finish,
    output logic [2:0]                 stage_sel,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [2:0] LAST_K   = 3'(NUM_STAGES - 1);
    localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT);

    state_t                       state_q, state_d;
    logic [2:0]                   k_q, k_d;
    logic [7:0]                   wd_q, wd_d;
    logic [NUM_STAGES-1:0]        start_q, start_d;
    logic                         done_q, done_d;
    logic                         error_q, error_d;
    logic [2:0]                   sel_q, sel_d;
    logic [FRAME_CNT_WIDTH-1:0]   frame_q, frame_d;

    logic [NUM_STAGES-1:0]        cur_oh;
    logic                         finish_hit;

    // Decode the active stage index and qualify its finish strobe; a finish
    // coinciding with that stage's own start pulse is not a real completion.
    always_comb begin
        cur_oh = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            cur_oh[i] = (k_q == 3'(i));
        end
        finish_hit = |(stage_finish & cur_oh & ~start_q);
    end

    // Next-state and registered-output logic: abort, then finish, then timeout.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        wd_d    = wd_q;
        start_d = '0;
        done_d  = 1'b0;
        error_d = error_q;
        sel_d   = sel_q;
        frame_d = frame_q;

        case (state_q)
            IDLE: begin
                if (fft_start) begin
                    state_d    = RUN;
                    k_d        = 3'd0;
                    wd_d       = 8'd0;
                    sel_d      = 3'd0;
                    error_d    = 1'b0;
                    start_d[0] = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                    sel_d   = 3'd0;
                end else if (finish_hit) begin
                    if (k_q != LAST_K) begin
                        k_d     = k_q + 3'd1;
                        sel_d   = sel_q + 3'd1;
                        start_d = cur_oh << 1;
                        wd_d    = 8'd0;
                    end else begin
                        done_d  = 1'b1;
                        frame_d = frame_q + 1'b1;
                        state_d = IDLE;
                        sel_d   = 3'd0;
                    end
                end else if (wd_q == WD_LIMIT) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                    sel_d   = 3'd0;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything immediately,
    // dropping any start pulse in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= 3'd0;
            wd_q    <= 8'd0;
            start_q <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            sel_q   <= 3'd0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            wd_q    <= wd_d;
            start_q <= start_d;
            done_q  <= done_d;
            error_q <= error_d;
            sel_q   <= sel_d;
            frame_q <= frame_d;
        end
    end

    assign fft_ready   = (state_q == IDLE);
    assign fft_busy    = (state_q == RUN);
    assign fft_done    = done_q;
    assign fft_error   = error_q;
    assign stage_start = start_q;
    assign stage_sel   = sel_q;
    assign frame_count = frame_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer. Each frame is described by per-stage finish
// latencies (and an optional abort cycle); expected start cycles, end cycle and
// outcome are computed arithmetically from those and compared every cycle.
// A narrow frame counter is used so its wrap is reached in a short run.
module tb_fft_stage_sequencer;

    localparam int NS  = 5;
    localparam int TO  = 15;
    localparam int FCW = 4;
    localparam int NEVER = 999;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           fft_start = 1'b0;
    logic           abort = 1'b0;
    logic [NS-1:0]  stage_finish = '0;
    logic           fft_ready, fft_busy, fft_done, fft_error;
    logic [NS-1:0]  stage_start;
    logic [2:0]     stage_sel;
    logic [FCW-1:0] frame_count;

    int checks = 0;
    int errors = 0;
    int exp_frames = 0;
    int exp_err = 0;
    int lat[NS];

    fft_stage_sequencer #(
        .NUM_STAGES(NS),
        .TIMEOUT(TO),
        .FRAME_CNT_WIDTH(FCW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fft_start(fft_start),
        .fft_ready(fft_ready),
        .fft_busy(fft_busy),
        .fft_done(fft_done),
        .fft_error(fft_error),
        .abort(abort),
        .stage_start(stage_start),
        .stage_finish(stage_finish),
        .stage_sel(stage_sel),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ready"}, 32'(fft_ready), 32'd1);
        chk({tag, "_busy"}, 32'(fft_busy), 32'd0);
        chk({tag, "_done"}, 32'(fft_done), 32'd0);
        chk({tag, "_error"}, 32'(fft_error), 32'd0);
        chk({tag, "_start"}, 32'(stage_start), 32'd0);
        chk({tag, "_sel"}, 32'(stage_sel), 32'd0);
        chk({tag, "_fcount"}, 32'(frame_count), 32'd0);
    endtask

    // One frame: request at the current cycle, accepted at the next edge (rel 0).
    // ab > 0 asserts abort during relative cycle ab. Leaves the bench in the
    // frame's final cycle (ready=1), so a following call runs back-to-back.
    task automatic run_frame(input bit noise, input bit rnd_start, input int ab);
        int s[NS];
        int end_rel;
        int err_stage;
        int cur;
        int kind; // 0 done, 1 timeout, 2 abort
        logic [NS-1:0] fin;
        logic [NS-1:0] exp_ss;

        s[0] = 1;
        for (int k = 1; k < NS; k++) s[k] = s[k-1] + lat[k-1] + 1;
        err_stage = -1;
        for (int k = 0; k < NS; k++)
            if (err_stage < 0 && lat[k] > TO) err_stage = k;
        if (err_stage < 0) begin
            kind = 0;
            end_rel = s[NS-1] + lat[NS-1] + 1;
        end else begin
            kind = 1;
            end_rel = s[err_stage] + TO + 1;
        end
        if (ab > 0 && ab < end_rel) begin
            kind = 2;
            end_rel = ab + 1;
        end

        fft_start = 1'b1;
        @(posedge clk); #1;
        fft_start = 1'b0;
        for (int rel = 1; rel <= end_rel; rel++) begin
            cur = 0;
            for (int k = 0; k < NS; k++) if (rel >= s[k]) cur = k;
            fin = '0;
            for (int k = 0; k < NS; k++) if (rel == s[k] + lat[k]) fin[k] = 1'b1;
            if (noise && rel < end_rel) begin
                for (int j = 0; j < NS; j++)
                    if (j != cur && $urandom_range(3) == 0) fin[j] = 1'b1;
                if (rel == s[cur] && $urandom_range(1) == 1) fin[cur] = 1'b1;
            end
            stage_finish = fin;
            abort = (rel == ab);
            fft_start = rnd_start && rel < end_rel && ($urandom_range(1) == 1);
            @(negedge clk);
            exp_ss = (rel < end_rel && rel == s[cur]) ? NS'(1 << cur) : '0;
            chk("stage_start", 32'(stage_start), 32'(exp_ss));
            chk("stage_sel", 32'(stage_sel), (rel < end_rel) ? 32'(cur) : 32'd0);
            chk("busy", 32'(fft_busy), 32'(rel < end_rel));
            chk("ready", 32'(fft_ready), 32'(rel == end_rel));
            chk("done", 32'(fft_done), 32'(kind == 0 && rel == end_rel));
            chk("error", 32'(fft_error), 32'(kind == 1 && rel == end_rel));
            if (rel < end_rel) begin
                @(posedge clk); #1;
            end
        end
        if (kind == 0) exp_frames = (exp_frames + 1) % (1 << FCW);
        exp_err = (kind == 1) ? 1 : 0;
        chk("frame_count", 32'(frame_count), 32'(exp_frames));
        stage_finish = '0;
        abort = 1'b0;
        fft_start = 1'b0;
    endtask

    // Idle cycles with noise on the finish lines: nothing may start.
    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            stage_finish = NS'($urandom_range((1 << NS) - 1));
            @(negedge clk);
            chk("idle_ready", 32'(fft_ready), 32'd1);
            chk("idle_start", 32'(stage_start), 32'd0);
            chk("idle_done", 32'(fft_done), 32'd0);
            chk("idle_error", 32'(fft_error), 32'(exp_err));
            chk("idle_fcount", 32'(frame_count), 32'(exp_frames));
        end
        stage_finish = '0;
    endtask

    initial begin
        int r;
        // Reset state, both during and after reset.
        #1;
        chk_reset_values("in_reset");
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_reset_values("post_reset");
        idle_gap(2);

        // Normal frame, every stage latency 4: starts 1,6,11,16,21, done 26.
        for (int k = 0; k < NS; k++) lat[k] = 4;
        run_frame(1'b0, 1'b0, 0);
        // Same with spurious finishes and ignored starts while busy.
        run_frame(1'b1, 1'b1, 0);
        idle_gap(1);

        // Stage 2 never finishes: error 16 cycles after its start.
        lat[2] = NEVER;
        run_frame(1'b0, 1'b0, 0);
        idle_gap(2);
        // Finish exactly at the watchdog limit wins; back-to-back frames.
        for (int k = 0; k < NS; k++) lat[k] = TO;
        run_frame(1'b0, 1'b0, 0);
        for (int k = 0; k < NS; k++) lat[k] = 1;
        run_frame(1'b1, 1'b0, 0);

        // Abort at the third cycle of stage 1.
        for (int k = 0; k < NS; k++) lat[k] = 4;
        run_frame(1'b0, 1'b0, 8);
        idle_gap(6);

        // Randomized frames; enough completions to wrap the counter.
        for (int f = 0; f < 45; f++) begin
            for (int k = 0; k < NS; k++) begin
                r = int'($urandom_range(19));
                if (r == 0) lat[k] = NEVER;
                else if (r == 1) lat[k] = TO;
                else lat[k] = int'($urandom_range(TO, 1));
            end
            run_frame(1'b1, 1'b1, ($urandom_range(7) == 0) ? int'($urandom_range(60, 1)) : 0);
            if ($urandom_range(1) == 1) idle_gap(int'($urandom_range(3, 1)));
        end

        // Make sure the counter is non-zero, then reset asynchronously mid stage 3.
        for (int k = 0; k < NS; k++) lat[k] = 4;
        if (exp_frames == 0) run_frame(1'b0, 1'b0, 0);
        fft_start = 1'b1;
        @(posedge clk); #1;
        fft_start = 1'b0;
        for (int rel = 1; rel < 18; rel++) begin
            stage_finish = (rel % 5 == 0) ? NS'(1 << (rel / 5 - 1)) : '0;
            @(posedge clk); #1;
        end
        stage_finish = '0;
        chk("pre_reset_sel", 32'(stage_sel), 32'd3);
        chk("pre_reset_busy", 32'(fft_busy), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk_reset_values("async_reset");
        @(negedge clk);
        reset = 1'b0;
        exp_frames = 0;
        exp_err = 0;
        idle_gap(2);
        run_frame(1'b0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard bound on simulated time so a wedged run still ends.
    initial begin
        #400000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "simulation time limit");
    end

endmodule
